// File: rtl/alu_pkg.sv
// Opcode encoding shared by the registered ALU, its issue front end and benches.
package alu_pkg;

    localparam int OPCODE_W = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_ADD = 3'd0;
    localparam opcode_t OP_SUB = 3'd1;
    localparam opcode_t OP_AND = 3'd2;
    localparam opcode_t OP_OR  = 3'd3;
    localparam opcode_t OP_XOR = 3'd4;
    localparam opcode_t OP_NOT = 3'd5;
    localparam opcode_t OP_SHL = 3'd6;
    localparam opcode_t OP_SHR = 3'd7;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and result buses of the ALU issue front end.
// The slave view is the issue controller; the master view is its environment.
interface alu_issue_ctrl_if import alu_pkg::*; #(
    parameter int WIDTH = 16
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [WIDTH-1:0]    cmd_a;
    logic [WIDTH-1:0]    cmd_b;
    logic [OPCODE_W-1:0] cmd_op;

    logic [WIDTH-1:0]    alu_in0;
    logic [WIDTH-1:0]    alu_in1;
    logic [OPCODE_W-1:0] alu_opcode;
    logic [WIDTH-1:0]    alu_out;
    logic                alu_overflow;

    logic                res_valid;
    logic                res_ready;
    logic [WIDTH-1:0]    res_data;
    logic                res_overflow;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready,
        output alu_in0, alu_in1, alu_opcode,
        input  alu_out, alu_overflow,
        output res_valid, res_data, res_overflow,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready,
        input  alu_in0, alu_in1, alu_opcode,
        output alu_out, alu_overflow,
        input  res_valid, res_data, res_overflow,
        output res_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers for full/empty.
// Reads as zero while empty; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers advance on accepted push/pop and wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-issue front end for the registered ALU: buffers commands, drives
// the ALU inputs under a credit limit, tracks ALU latency with a valid delay
// line and collects results in issue order into a show-ahead result FIFO.
module alu_issue_ctrl import alu_pkg::*; #(
    parameter int WIDTH     = 16,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_ctrl_if.slave        bus,
    output logic                   idle
);

    localparam int CMD_W = OPCODE_W + 2 * WIDTH;
    localparam int RES_W = WIDTH + 1;
    localparam int CRW   = $clog2(RES_DEPTH + 1);

    logic             cmd_push;
    logic             cmd_full;
    logic             cmd_empty;
    logic [CMD_W-1:0] cmd_rdata;

    logic             res_push;
    logic             res_pop;
    logic             res_full;
    logic             res_empty;
    logic [RES_W-1:0] res_rdata;

    logic             issue;
    logic [CRW-1:0]   credits;
    logic [ALU_LAT:0] inflight;

    assign cmd_push      = bus.cmd_valid && !cmd_full;
    assign bus.cmd_ready = !cmd_full;

    assign issue = !cmd_empty && (credits != '0);

    assign res_push = inflight[ALU_LAT];
    assign res_pop  = bus.res_ready && !res_empty;

    assign bus.res_valid                      = !res_empty;
    assign {bus.res_overflow, bus.res_data}   = res_rdata;

    assign idle = cmd_empty && (inflight == '0) && res_empty;

    sync_fifo #(
        .W     (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .wdata ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop   (issue),
        .rdata (cmd_rdata),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(
        .W     (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .wdata ({bus.alu_overflow, bus.alu_out}),
        .pop   (res_pop),
        .rdata (res_rdata),
        .full  (res_full),
        .empty (res_empty)
    );

    // ALU input registers load the head command on issue and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_in0    <= '0;
            bus.alu_in1    <= '0;
            bus.alu_opcode <= '0;
        end else if (issue) begin
            bus.alu_opcode <= cmd_rdata[CMD_W-1 -: OPCODE_W];
            bus.alu_in0    <= cmd_rdata[2*WIDTH-1 -: WIDTH];
            bus.alu_in1    <= cmd_rdata[WIDTH-1:0];
        end
    end

    // Credits reserve result FIFO space for every op issued but not yet popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits <= CRW'(RES_DEPTH);
        end else if (issue && !res_pop) begin
            credits <= credits - CRW'(1);
        end else if (!issue && res_pop) begin
            credits <= credits + CRW'(1);
        end
    end

    // Valid delay line marks the cycle in which the ALU output belongs to an op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= {inflight[ALU_LAT-1:0], issue};
        end
    end

    // The credit scheme guarantees a result always finds a free slot.
    always_ff @(posedge clk) begin
        if (rst_n && res_push) begin
            assert (!res_full);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and scoreboarded bench for alu_issue_ctrl with a registered ALU stub.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int WIDTH     = 16;
    localparam int RES_DEPTH = 4;

    logic clk;
    logic rst_n;
    logic idle;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(
        .WIDTH     (WIDTH),
        .CMD_DEPTH (4),
        .RES_DEPTH (RES_DEPTH),
        .ALU_LAT   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .idle  (idle)
    );

    int checks   = 0;
    int failures = 0;

    int  cycle        = 0;
    int  acceptCount  = 0;
    int  creditErrors = 0;
    bit  lastAccepted = 0;
    bit  scoreOn      = 0;

    logic [16:0] gotQ[$];
    int          gotCycle[$];
    logic [16:0] expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU behaviour: {overflow, result}.
    function automatic logic [16:0] aluModel(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        logic [15:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: r = a << b[3:0];
            default: r = a >> b[3:0];
        endcase
        return {ov, r};
    endfunction

    // Registered ALU stub with one edge of latency.
    always @(posedge clk) begin
        {bus.alu_overflow, bus.alu_out} <= aluModel(bus.alu_in0, bus.alu_in1, bus.alu_opcode);
    end

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(bit valid, logic [15:0] a, logic [15:0] b, logic [2:0] op, bit ready);
        bus.cmd_valid = valid;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.res_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: samples mid-cycle what will transfer at the next edge.
    always @(negedge clk) begin
        cycle++;
        lastAccepted = rst_n && bus.cmd_valid && bus.cmd_ready;
        if (lastAccepted) begin
            acceptCount++;
            if (scoreOn) expQ.push_back(aluModel(bus.cmd_a, bus.cmd_b, bus.cmd_op));
        end
        if (rst_n && bus.res_valid && bus.res_ready) begin
            gotQ.push_back({bus.res_overflow, bus.res_data});
            gotCycle.push_back(cycle);
            if (scoreOn) begin
                if (expQ.size() == 0) checkOutput("sb_unexpected", 1, 0);
                else checkOutput("sb_result", {bus.res_overflow, bus.res_data}, expQ.pop_front());
            end
        end
        if (dut.credits > RES_DEPTH) creditErrors++;
    end

    logic [16:0] streamExp [8];
    int sent;

    initial begin
        streamExp = '{17'h00018, 17'h0FFF0, 17'h00004, 17'h00014,
                      17'h00010, 17'h0FFFB, 17'h00040, 17'h00000};
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset state
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_res_data", bus.res_data, 0);
        checkOutput("rst_res_ovf", bus.res_overflow, 0);
        checkOutput("rst_alu_in0", bus.alu_in0, 0);
        checkOutput("rst_alu_in1", bus.alu_in1, 0);
        checkOutput("rst_alu_op", bus.alu_opcode, 0);
        checkOutput("rst_idle", idle, 1);

        rst_n = 1'b1;
        tick();

        // Single op latency: accept at A, issue at A+1, result after A+3
        applyStimulus(1, 16'd4, 16'd20, OP_ADD, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("single_valid_a0", bus.res_valid, 0);
        tick();
        checkOutput("single_in0", bus.alu_in0, 4);
        checkOutput("single_in1", bus.alu_in1, 20);
        checkOutput("single_op", bus.alu_opcode, OP_ADD);
        tick();
        checkOutput("single_valid_a2", bus.res_valid, 0);
        tick();
        checkOutput("single_valid_a3", bus.res_valid, 1);
        checkOutput("single_data", bus.res_data, 24);
        checkOutput("single_ovf", bus.res_overflow, 0);
        tick();
        checkOutput("single_idle", idle, 1);

        // Stream all opcodes back to back
        gotQ.delete(); gotCycle.delete(); acceptCount = 0;
        for (int op = 0; op < 8; op++) begin
            applyStimulus(1, 16'd4, 16'd20, op[2:0], 1);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 30 && gotQ.size() < 8; k++) tick();
        checkOutput("stream_accepts", acceptCount, 8);
        checkOutput("stream_count", gotQ.size(), 8);
        if (gotQ.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("stream_res%0d", k), gotQ[k], streamExp[k]);
                checkOutput($sformatf("stream_gap%0d", k), gotCycle[k] - gotCycle[0], k);
            end
        end

        // Signed overflow on add and sub
        gotQ.delete();
        applyStimulus(1, 16'h7FFF, 16'h0001, OP_ADD, 1);
        tick();
        applyStimulus(1, 16'h8000, 16'h0001, OP_SUB, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 20 && gotQ.size() < 2; k++) tick();
        checkOutput("ovf_count", gotQ.size(), 2);
        if (gotQ.size() == 2) begin
            checkOutput("ovf_add", gotQ[0], 17'h18000);
            checkOutput("ovf_sub", gotQ[1], 17'h17FFF);
        end

        // Back-pressure: consumer stalled, ten commands offered
        gotQ.delete(); acceptCount = 0; sent = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(sent < 10, 16'(sent + 1), 16'd100, OP_ADD, 0);
            tick();
            if (lastAccepted) sent++;
        end
        checkOutput("bp_accepted", acceptCount, 8);
        checkOutput("bp_cmd_ready", bus.cmd_ready, 0);
        checkOutput("bp_in0_frozen", bus.alu_in0, 4);
        checkOutput("bp_in1_frozen", bus.alu_in1, 100);
        checkOutput("bp_head", bus.res_data, 101);
        for (int k = 0; k < 100 && (sent < 10 || gotQ.size() < 10); k++) begin
            applyStimulus(sent < 10, 16'(sent + 1), 16'd100, OP_ADD, 1);
            tick();
            if (lastAccepted) sent++;
        end
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("bp_drain_count", gotQ.size(), 10);
        if (gotQ.size() == 10) begin
            for (int k = 0; k < 10; k++) checkOutput($sformatf("bp_res%0d", k), gotQ[k], 101 + k);
        end
        checkOutput("bp_idle", idle, 1);

        // Pop and issue contend while credits are zero
        gotQ.delete(); sent = 0;
        for (int k = 0; k < 20 && sent < 5; k++) begin
            applyStimulus(1, 16'(16'h10 + sent), 16'd0, OP_ADD, 0);
            tick();
            if (lastAccepted) sent++;
        end
        applyStimulus(0, 0, 0, 0, 0);
        repeat (6) tick();
        checkOutput("cz_in0_before", bus.alu_in0, 16'h13);
        checkOutput("cz_head", bus.res_data, 16'h10);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("cz_issue_blocked", bus.alu_in0, 16'h13);
        tick();
        checkOutput("cz_issue_next", bus.alu_in0, 16'h14);
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 20 && !idle; k++) tick();
        checkOutput("cz_count", gotQ.size(), 5);
        if (gotQ.size() == 5) checkOutput("cz_last", gotQ[4], 16'h14);

        // Randomised traffic against the scoreboard
        gotQ.delete(); expQ.delete(); sent = 0; scoreOn = 1;
        for (int k = 0; k < 20000 && (sent < 1000 || expQ.size() != 0); k++) begin
            applyStimulus((sent < 1000) && ($urandom_range(0, 1) == 1), 16'($urandom),
                          16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            tick();
            if (lastAccepted) sent++;
        end
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) tick();
        scoreOn = 0;
        checkOutput("rand_sent", sent, 1000);
        checkOutput("rand_received", gotQ.size(), 1000);
        checkOutput("rand_pending", expQ.size(), 0);
        checkOutput("rand_idle", idle, 1);

        // Reset in the middle of queued and in-flight work
        gotQ.delete(); sent = 0;
        for (int k = 0; k < 10 && sent < 3; k++) begin
            applyStimulus(1, 16'(sent + 1), 16'd2, OP_SUB, 0);
            tick();
            if (lastAccepted) sent++;
        end
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("mid_cmd_ready", bus.cmd_ready, 1);
        checkOutput("mid_res_valid", bus.res_valid, 0);
        checkOutput("mid_alu_in0", bus.alu_in0, 0);
        checkOutput("mid_alu_op", bus.alu_opcode, 0);
        checkOutput("mid_idle", idle, 1);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        repeat (5) tick();
        checkOutput("mid_no_results", gotQ.size(), 0);
        checkOutput("mid_idle_after", idle, 1);

        checkOutput("credit_range", creditErrors, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
